instr_fetch: RTL and testbench

Instruction fetch stage for the RV32I single-issue core. Holds the program counter, fetches 32-bit words from instruction memory over a request/valid handshake, and presents each instruction with its pre-sliced fields (op, funct3, funct7b5, rd, rs1, rs2) to the control unit and register file. A ready/valid handshake connects it to the decode side. The control unit's `pcSrc` decision, together with the branch/jump target, is returned here to select the next PC.

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the RV32I single-issue core.
// Holds the PC, fetches one word per request/valid handshake, and presents
// the held instruction with pre-sliced fields over a ready/valid handshake.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic        fetchFault,
    output logic [31:0] instrCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        accept;
    logic        target_misaligned;

    assign accept            = (state_q == HOLD) && instrReady;
    assign target_misaligned = (pcTarget[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imemValid) state_d = HOLD;
            HOLD: begin
                if (accept) begin
                    if (pcSrc && target_misaligned) begin
                        state_d = FAULT;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: instruction capture, PC update, fault and count
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        count_d = count_q;
        if ((state_q == FETCH) && imemValid) begin
            instr_d = imemRdata;
        end
        if (accept) begin
            count_d = count_q + 32'd1;
            if (pcSrc) begin
                pc_d = pcTarget;
                if (target_misaligned) begin
                    fault_d = 1'b1;
                end
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    // Outputs decoded from state and registered datapath
    always_comb begin
        imemReq    = (state_q == FETCH);
        instrValid = (state_q == HOLD);
        imemAddr   = pc_q;
        pc         = pc_q;
        pcPlus4    = pc_q + 32'd4;
        instr      = instr_q;
        op         = instr_q[6:0];
        funct3     = instr_q[14:12];
        funct7b5   = instr_q[30];
        rd         = instr_q[11:7];
        rs1        = instr_q[19:15];
        rs2        = instr_q[24:20];
        fetchFault = fault_q;
        instrCount = count_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected (pc, word)
// pairs when memory answers a request; a negedge monitor pops on accept.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, pcPlus4;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        fetchFault;
    logic [31:0] instrCount;

    // Second instance for the PC wrap-around case
    logic        w_rst;
    logic        w_imemReq;
    logic [31:0] w_imemAddr;
    logic        w_imemValid;
    logic [31:0] w_imemRdata;
    logic        w_instrValid;
    logic        w_instrReady;
    logic [31:0] w_instr;
    logic [6:0]  w_op;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_pc, w_pcPlus4;
    logic        w_pcSrc;
    logic [31:0] w_pcTarget;
    logic        w_fetchFault;
    logic [31:0] w_instrCount;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemValid(imemValid), .imemRdata(imemRdata), .instrValid(instrValid),
        .instrReady(instrReady), .instr(instr), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .pc(pc),
        .pcPlus4(pcPlus4), .pcSrc(pcSrc), .pcTarget(pcTarget),
        .fetchFault(fetchFault), .instrCount(instrCount)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst), .imemReq(w_imemReq), .imemAddr(w_imemAddr),
        .imemValid(w_imemValid), .imemRdata(w_imemRdata), .instrValid(w_instrValid),
        .instrReady(w_instrReady), .instr(w_instr), .op(w_op), .funct3(w_funct3),
        .funct7b5(w_funct7b5), .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2), .pc(w_pc),
        .pcPlus4(w_pcPlus4), .pcSrc(w_pcSrc), .pcTarget(w_pcTarget),
        .fetchFault(w_fetchFault), .instrCount(w_instrCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];

    // Reference model: architectural view of the fetch stage
    logic [31:0] model_pc    = RST_PC;
    logic        model_fault = 1'b0;
    logic [31:0] model_count = 32'd0;
    int unsigned acc_cnt     = 0;

    // Stimulus knobs
    int unsigned min_wait  = 0;
    int unsigned max_wait  = 0;
    int unsigned ready_pct = 100;
    int unsigned src_pct   = 0;
    bit          stray_en  = 1'b0;
    bit          br_en     = 1'b0;
    logic [31:0] br_pc     = 32'd0;
    logic [31:0] br_tgt    = 32'd0;

    bit          mem_active = 1'b0;
    int unsigned mem_wait   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One cycle of stimulus, applied 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        imemValid = 1'b0;
        imemRdata = $urandom;
        if (rst) begin
            mem_active = 1'b0;
        end else if (imemReq) begin
            chk("imemAddr", imemAddr, model_pc);
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_wait   = $urandom_range(max_wait, min_wait);
            end
            if (mem_wait == 0) begin
                exp_t e;
                imemValid  = 1'b1;
                imemRdata  = rd_mem(imemAddr);
                e.pc       = model_pc;
                e.word     = rd_mem(model_pc);
                exp_q.push_back(e);
                mem_active = 1'b0;
            end else begin
                mem_wait--;
            end
        end else begin
            mem_active = 1'b0;
            if (stray_en && ($urandom_range(3, 0) == 0)) imemValid = 1'b1;
        end
        instrReady = ($urandom_range(99, 0) < ready_pct);
        pcSrc      = ($urandom_range(99, 0) < src_pct);
        pcTarget   = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
        if (br_en && instrValid && (pc == br_pc)) begin
            instrReady = 1'b1;
            pcSrc      = 1'b1;
            pcTarget   = br_tgt;
        end
    endtask

    function automatic bit cond(input int unsigned what);
        case (what)
            0:       return imemReq;
            1:       return instrValid;
            2:       return fetchFault;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int unsigned what, input int unsigned budget, input string nm);
        int unsigned n = 0;
        while (!cond(what) && (n < budget)) begin
            step();
            n++;
        end
        chk(nm, {31'd0, cond(what)}, 32'd1);
    endtask

    task automatic wait_accepts(input int unsigned target, input int unsigned budget, input string nm);
        int unsigned n = 0;
        while ((acc_cnt < target) && (n < budget)) begin
            step();
            n++;
        end
        chk(nm, {31'd0, acc_cnt >= target}, 32'd1);
    endtask

    // Hold reset for n cycles with stray imemValid pulses, then release with
    // one more stray pulse in the IDLE cycle that follows.
    task automatic do_reset(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step();
            rst       = 1'b1;
            imemValid = 1'b1;
            imemRdata = $urandom;
        end
        step();
        rst       = 1'b0;
        imemValid = 1'b1;
        imemRdata = $urandom;
    endtask

    // Monitor: sample at the falling edge, compare against the scoreboard
    initial begin : monitor
        exp_t        e;
        bit          rst_seen  = 1'b0;
        bit          prev_hold = 1'b0;
        logic [31:0] held_i    = '0;
        logic [31:0] held_p    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rst_seen) begin
                    chk("rst_imemReq", {31'd0, imemReq}, 32'd0);
                    chk("rst_instrValid", {31'd0, instrValid}, 32'd0);
                    chk("rst_instr", instr, 32'd0);
                    chk("rst_imemAddr", imemAddr, RST_PC);
                    chk("rst_pc", pc, RST_PC);
                    chk("rst_pcPlus4", pcPlus4, RST_PC + 32'd4);
                    chk("rst_fetchFault", {31'd0, fetchFault}, 32'd0);
                    chk("rst_instrCount", instrCount, 32'd0);
                end
                rst_seen    = 1'b1;
                model_pc    = RST_PC;
                model_fault = 1'b0;
                model_count = 32'd0;
                prev_hold   = 1'b0;
                exp_q.delete();
            end else begin
                rst_seen = 1'b0;
                chk("fetchFault", {31'd0, fetchFault}, {31'd0, model_fault});
                if (model_fault) begin
                    chk("fault_imemReq", {31'd0, imemReq}, 32'd0);
                    chk("fault_instrValid", {31'd0, instrValid}, 32'd0);
                    chk("fault_pc", pc, model_pc);
                end
                if (prev_hold) begin
                    chk("hold_valid", {31'd0, instrValid}, 32'd1);
                    chk("hold_instr", instr, held_i);
                    chk("hold_pc", pc, held_p);
                end
                if (instrValid) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", {31'd0, instrValid}, 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("instr", instr, e.word);
                        chk("pc", pc, e.pc);
                        chk("pcPlus4", pcPlus4, e.pc + 32'd4);
                        chk("op", {25'd0, op}, {25'd0, e.word[6:0]});
                        chk("funct3", {29'd0, funct3}, {29'd0, e.word[14:12]});
                        chk("funct7b5", {31'd0, funct7b5}, {31'd0, e.word[30]});
                        chk("rd", {27'd0, rd}, {27'd0, e.word[11:7]});
                        chk("rs1", {27'd0, rs1}, {27'd0, e.word[19:15]});
                        chk("rs2", {27'd0, rs2}, {27'd0, e.word[24:20]});
                        chk("instrCount", instrCount, model_count);
                        if (instrReady) begin
                            void'(exp_q.pop_front());
                            model_count = model_count + 32'd1;
                            if (pcSrc) begin
                                model_pc = pcTarget;
                                if (pcTarget[1:0] != 2'b00) model_fault = 1'b1;
                            end else begin
                                model_pc = model_pc + 32'd4;
                            end
                            acc_cnt++;
                        end
                    end
                end
                prev_hold = instrValid && !instrReady;
                held_i    = instr;
                held_p    = pc;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int unsigned base;
        rst          = 1'b1;
        imemValid    = 1'b0;
        imemRdata    = '0;
        instrReady   = 1'b0;
        pcSrc        = 1'b0;
        pcTarget     = '0;
        w_rst        = 1'b1;
        w_imemValid  = 1'b1;
        w_imemRdata  = 32'h0000_0013;
        w_instrReady = 1'b1;
        w_pcSrc      = 1'b0;
        w_pcTarget   = '0;

        // Reset and sequential fetch, zero-wait memory
        mem[32'h0] = 32'h0000_0033;
        mem[32'h4] = 32'h0040_0093;
        mem[32'h8] = 32'h0000_2023;
        do_reset(3);
        base = acc_cnt;
        wait_for(0, 10, "seq_first_req");
        chk("seq_first_addr", imemAddr, 32'h0);
        wait_accepts(base + 3, 20, "seq_accepts");
        chk("seq_count3", instrCount, 32'd3);

        // Branch taken from the beq at pc 8
        mem[32'h8]  = 32'h0000_0063;
        mem[32'h40] = 32'h0000_0013;
        br_en  = 1'b1;
        br_pc  = 32'h8;
        br_tgt = 32'h40;
        do_reset(2);
        base = acc_cnt;
        wait_accepts(base + 3, 20, "br_accepts");
        wait_for(0, 10, "br_req");
        chk("br_addr", imemAddr, 32'h40);
        wait_for(1, 10, "br_valid");
        chk("br_pc", pc, 32'h40);
        chk("br_pcPlus4", pcPlus4, 32'h44);
        br_en = 1'b0;

        // Wait states and backpressure; pcSrc pulsed while not ready
        min_wait  = 3;
        max_wait  = 3;
        ready_pct = 0;
        src_pct   = 100;
        do_reset(2);
        wait_for(1, 20, "bp_valid");
        for (int unsigned i = 0; i < 3; i++) step();
        ready_pct = 100;
        src_pct   = 0;
        wait_for(0, 10, "bp_req");
        chk("bp_next_addr", imemAddr, 32'h4);

        // Misaligned jump taken from pc 4
        br_en  = 1'b1;
        br_pc  = 32'h4;
        br_tgt = 32'h102;
        wait_for(2, 30, "mis_fault");
        for (int unsigned i = 0; i < 5; i++) step();
        chk("mis_imemReq", {31'd0, imemReq}, 32'd0);
        chk("mis_pc", pc, 32'h102);
        chk("mis_fetchFault", {31'd0, fetchFault}, 32'd1);
        br_en = 1'b0;
        do_reset(2);
        chk("mis_cleared", {31'd0, fetchFault}, 32'd0);
        wait_for(0, 10, "mis_restart_req");
        chk("mis_restart_addr", imemAddr, RST_PC);

        // Reset while a fetch is outstanding
        step();
        chk("mid_in_fetch", {31'd0, imemReq}, 32'd1);
        do_reset(3);
        step();
        chk("mid_instrValid", {31'd0, instrValid}, 32'd0);
        chk("mid_imemReq", {31'd0, imemReq}, 32'd1);
        chk("mid_addr", imemAddr, RST_PC);
        chk("mid_count", instrCount, 32'd0);

        // Randomized traffic
        min_wait  = 0;
        max_wait  = 3;
        ready_pct = 60;
        src_pct   = 25;
        stray_en  = 1'b1;
        do_reset(2);
        for (int unsigned i = 0; i < 1500; i++) step();
        stray_en = 1'b0;

        // Quiesce the main instance, then exercise PC wrap-around
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        w_rst = 1'b0;
        @(negedge clk);
        chk("wrap_idle_req", {31'd0, w_imemReq}, 32'd0);
        chk("wrap_idle_addr", w_imemAddr, 32'hFFFF_FFFC);
        chk("wrap_idle_pcPlus4", w_pcPlus4, 32'h0);
        @(posedge clk);
        #1;
        chk("wrap_req1", {31'd0, w_imemReq}, 32'd1);
        chk("wrap_addr1", w_imemAddr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        chk("wrap_valid", {31'd0, w_instrValid}, 32'd1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pcPlus4", w_pcPlus4, 32'h0);
        chk("wrap_instr", w_instr, 32'h0000_0013);
        @(posedge clk);
        #1;
        chk("wrap_req2", {31'd0, w_imemReq}, 32'd1);
        chk("wrap_addr2", w_imemAddr, 32'h0);
        chk("wrap_fault", {31'd0, w_fetchFault}, 32'd0);
        chk("wrap_count", w_instrCount, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
